// File: rtl/clk_switch_pkg.sv
// Shared types and widths for the clock-switch controller.
package clk_switch_pkg;
   localparam int CLK_SEL_W = 2;
   localparam int CNT_W     = 10;  // covers TIMEOUT_CYCLES up to 1023

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      DRAIN   = 3'd1,
      SWITCH  = 3'd2,
      SETTLE  = 3'd3,
      RELEASE = 3'd4
   } state_t;
endpackage

// File: rtl/clk_sw_cnt.sv
// Loadable down-counter with a zero flag; it serves as both the settle
// counter and the quiesce timeout counter.
module clk_sw_cnt #(
   parameter int W = 10
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic         en,
   input  logic [W-1:0] load_val,
   output logic         zero
);
   logic [W-1:0] cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                   cnt <= '0;
      else if (load)             cnt <= load_val;
      else if (en && cnt != '0)  cnt <= cnt - 1'b1;
   end

   assign zero = (cnt == '0);
endmodule

// File: rtl/clk_switch_ctrl.sv
// Glitch-free clock mux select controller: quiesce, switch, settle, release.
// Define CLK_SW_TIMEOUT_EN to bound the wait for quiesce_ack.
module clk_switch_ctrl
   import clk_switch_pkg::*;
#(
   parameter int SETTLE_CYCLES  = 16,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 req_valid,
   input  logic [CLK_SEL_W-1:0] req_sel,
   output logic                 req_ready,
   output logic                 quiesce_req,
   input  logic                 quiesce_ack,
   output logic [CLK_SEL_W-1:0] sel_out,
   output logic                 busy,
   output logic                 done,
   output logic                 err
);
   state_t               state, nxt;
   logic [CLK_SEL_W-1:0] tgt;
   logic                 same_done;
   logic                 accept;
   logic                 cnt_load, cnt_en, cnt_zero;
   logic [CNT_W-1:0]     cnt_val;

   assign req_ready = (state == IDLE) && !rst;
   assign accept    = req_valid && req_ready;

   always_comb begin
      nxt      = state;
      cnt_load = 1'b0;
      cnt_en   = 1'b0;
      cnt_val  = '0;
      case (state)
         IDLE: begin
            if (accept && req_sel != sel_out) begin
               nxt = DRAIN;
`ifdef CLK_SW_TIMEOUT_EN
               cnt_load = 1'b1;
               cnt_val  = CNT_W'(TIMEOUT_CYCLES - 1);
`endif
            end
         end
         DRAIN: begin
            // ack wins over a timeout expiring in the same cycle
            if (quiesce_ack) nxt = SWITCH;
`ifdef CLK_SW_TIMEOUT_EN
            else if (cnt_zero) nxt = RELEASE;
            else cnt_en = 1'b1;
`endif
         end
         SWITCH: begin
            cnt_load = 1'b1;
            cnt_val  = CNT_W'(SETTLE_CYCLES - 1);
            nxt      = SETTLE;
         end
         SETTLE: begin
            cnt_en = 1'b1;
            if (cnt_zero) nxt = RELEASE;
         end
         RELEASE: nxt = IDLE;
         default: nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         tgt       <= '0;
         sel_out   <= '0;
         same_done <= 1'b0;
      end else begin
         state     <= nxt;
         same_done <= accept && (req_sel == sel_out);
         if (accept) tgt <= req_sel;
         if (state == DRAIN && quiesce_ack) sel_out <= tgt;
      end
   end

   clk_sw_cnt #(.W(CNT_W)) u_cnt (
      .clk      (clk),
      .rst      (rst),
      .load     (cnt_load),
      .en       (cnt_en),
      .load_val (cnt_val),
      .zero     (cnt_zero)
   );

`ifdef CLK_SW_TIMEOUT_EN
   logic timed_out;
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                                             timed_out <= 1'b0;
      else if (state == IDLE)                              timed_out <= 1'b0;
      else if (state == DRAIN && !quiesce_ack && cnt_zero) timed_out <= 1'b1;
   end
   assign err = (state == RELEASE) && timed_out;
`else
   assign err = 1'b0;
`endif

   assign quiesce_req = (state == DRAIN) || (state == SWITCH) || (state == SETTLE);
   assign busy        = (state != IDLE);
   assign done        = (state == RELEASE) || same_done;
endmodule

// File: tb/tb_clk_switch_ctrl.sv
// Directed bench for clk_switch_ctrl with SETTLE=16, TIMEOUT=64.
module tb_clk_switch_ctrl;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       req_valid = 1'b0;
   logic [1:0] req_sel = 2'd0;
   logic       req_ready, quiesce_req, busy, done, err;
   logic       quiesce_ack = 1'b0;
   logic [1:0] sel_out;
   int         vec = 0;
   int         miscmp = 0;

   clk_switch_ctrl #(.SETTLE_CYCLES(16), .TIMEOUT_CYCLES(64)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_sel(req_sel),
      .req_ready(req_ready), .quiesce_req(quiesce_req), .quiesce_ack(quiesce_ack),
      .sel_out(sel_out), .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      step(); step();
      vec++; if ({sel_out, busy, req_ready, done, quiesce_req, err} !== 7'b0) begin
         miscmp++; $display("FAIL reset_outputs got sel=%0d busy=%b rdy=%b done=%b qreq=%b err=%b want all 0",
                            sel_out, busy, req_ready, done, quiesce_req, err);
      end
      rst = 1'b0; #1;
      vec++; if (req_ready !== 1'b1 || busy !== 1'b0) begin
         miscmp++; $display("FAIL reset_release got rdy=%b busy=%b want 1 0", req_ready, busy);
      end
   endtask

   // Request sel=2 with ack tied high: sel_out at T+2, done at T+19.
   task automatic test_switch();
      int bad_q = 0;
      quiesce_ack = 1'b1;
      req_sel = 2'd2; req_valid = 1'b1;
      step(); req_valid = 1'b0;              // T+1
      vec++; if (busy !== 1'b1 || quiesce_req !== 1'b1 || sel_out !== 2'd0 || req_ready !== 1'b0) begin
         miscmp++; $display("FAIL switch_t1 got busy=%b qreq=%b sel=%0d rdy=%b want 1 1 0 0", busy, quiesce_req, sel_out, req_ready);
      end
      step();                                // T+2
      vec++; if (sel_out !== 2'd2) begin
         miscmp++; $display("FAIL switch_sel_t2 got %0d want 2", sel_out);
      end
      for (int c = 3; c <= 18; c++) begin
         step();
         if (quiesce_req !== 1'b1 || done !== 1'b0) bad_q++;
      end
      vec++; if (bad_q != 0) begin
         miscmp++; $display("FAIL switch_hold got %0d bad cycles want 0", bad_q);
      end
      step();                                // T+19
      vec++; if (done !== 1'b1 || quiesce_req !== 1'b0 || err !== 1'b0) begin
         miscmp++; $display("FAIL switch_done_t19 got done=%b qreq=%b err=%b want 1 0 0", done, quiesce_req, err);
      end
      step();                                // T+20
      vec++; if (done !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b1) begin
         miscmp++; $display("FAIL switch_idle got done=%b busy=%b rdy=%b want 0 0 1", done, busy, req_ready);
      end
   endtask

   task automatic test_same_sel();
      req_sel = 2'd2; req_valid = 1'b1;
      step(); req_valid = 1'b0;              // T+1
      vec++; if (done !== 1'b1 || busy !== 1'b0 || quiesce_req !== 1'b0 || sel_out !== 2'd2) begin
         miscmp++; $display("FAIL same_sel got done=%b busy=%b qreq=%b sel=%0d want 1 0 0 2", done, busy, quiesce_req, sel_out);
      end
      step();
      vec++; if (done !== 1'b0 || quiesce_req !== 1'b0) begin
         miscmp++; $display("FAIL same_sel_pulse got done=%b qreq=%b want 0 0", done, quiesce_req);
      end
   endtask

   // Ack arrives late, a stray request lands while busy, ack drops after DRAIN.
   task automatic test_delayed_ack();
      int bad = 0;
      int n = 0;
      quiesce_ack = 1'b0;
      req_sel = 2'd1; req_valid = 1'b1;
      step(); req_valid = 1'b0;              // T+1, DRAIN
      for (int i = 0; i < 9; i++) begin
         if (i == 4) begin req_valid = 1'b1; req_sel = 2'd3; end
         else req_valid = 1'b0;
         step();
         if (sel_out !== 2'd2 || busy !== 1'b1 || quiesce_req !== 1'b1) bad++;
      end
      req_valid = 1'b0;
      vec++; if (bad != 0) begin
         miscmp++; $display("FAIL drain_wait got %0d bad cycles want 0", bad);
      end
      quiesce_ack = 1'b1;
      step();                                // SWITCH
      quiesce_ack = 1'b0;
      vec++; if (sel_out !== 2'd1) begin
         miscmp++; $display("FAIL ack_sel got %0d want 1", sel_out);
      end
      while (done !== 1'b1 && n < 40) begin step(); n++; end
      vec++; if (n != 17) begin
         miscmp++; $display("FAIL ack_done_lat got %0d cycles want 17", n);
      end
      vec++; if (sel_out !== 2'd1 || err !== 1'b0) begin
         miscmp++; $display("FAIL ack_done_sel got sel=%0d err=%b want 1 0", sel_out, err);
      end
      bad = 0;
      for (int i = 0; i < 4; i++) begin
         step();
         if (busy !== 1'b0 || sel_out !== 2'd1 || done !== 1'b0) bad++;
      end
      vec++; if (bad != 0) begin
         miscmp++; $display("FAIL no_queue got %0d bad cycles want 0", bad);
      end
   endtask

`ifdef CLK_SW_TIMEOUT_EN
   task automatic test_timeout();
      int bad = 0;
      quiesce_ack = 1'b0;
      req_sel = 2'd0; req_valid = 1'b1;
      step(); req_valid = 1'b0;              // T+1
      for (int c = 1; c < 64; c++) begin
         if (done !== 1'b0 || err !== 1'b0 || sel_out !== 2'd1 || quiesce_req !== 1'b1) bad++;
         step();
      end
      if (done !== 1'b0 || quiesce_req !== 1'b1) bad++;   // T+64
      vec++; if (bad != 0) begin
         miscmp++; $display("FAIL timeout_wait got %0d bad cycles want 0", bad);
      end
      step();                                // T+65
      vec++; if (done !== 1'b1 || err !== 1'b1 || quiesce_req !== 1'b0 || sel_out !== 2'd1) begin
         miscmp++; $display("FAIL timeout_release got done=%b err=%b qreq=%b sel=%0d want 1 1 0 1", done, err, quiesce_req, sel_out);
      end
      step();
      vec++; if (err !== 1'b0 || busy !== 1'b0) begin
         miscmp++; $display("FAIL timeout_after got err=%b busy=%b want 0 0", err, busy);
      end
   endtask
`endif

   // Reset lands in SETTLE, then a fresh request for sel=3 completes.
   task automatic test_reset_mid();
      int n = 1;
      quiesce_ack = 1'b1;
      req_sel = 2'd2; req_valid = 1'b1;
      step(); req_valid = 1'b0;
      for (int i = 0; i < 4; i++) step();    // T+5, SETTLE
      vec++; if (sel_out !== 2'd2 || busy !== 1'b1) begin
         miscmp++; $display("FAIL mid_pre got sel=%0d busy=%b want 2 1", sel_out, busy);
      end
      rst = 1'b1; #1;
      vec++; if (sel_out !== 2'd0 || busy !== 1'b0 || quiesce_req !== 1'b0 || req_ready !== 1'b0) begin
         miscmp++; $display("FAIL mid_reset got sel=%0d busy=%b qreq=%b rdy=%b want 0 0 0 0", sel_out, busy, quiesce_req, req_ready);
      end
      step(); rst = 1'b0; #1;
      vec++; if (req_ready !== 1'b1 || busy !== 1'b0) begin
         miscmp++; $display("FAIL mid_release got rdy=%b busy=%b want 1 0", req_ready, busy);
      end
      req_sel = 2'd3; req_valid = 1'b1;
      step(); req_valid = 1'b0;              // T+1
      while (done !== 1'b1 && n < 40) begin step(); n++; end
      vec++; if (n != 19 || sel_out !== 2'd3) begin
         miscmp++; $display("FAIL mid_new_req got lat=%0d sel=%0d want 19 3", n, sel_out);
      end
   endtask

   initial begin
      test_reset();
      test_switch();
      test_same_sel();
      test_delayed_ack();
`ifdef CLK_SW_TIMEOUT_EN
      test_timeout();
`endif
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vec, miscmp);
      $finish;
   end
endmodule
